// File: rtl/pipelined_barrel_shifter_pkg.sv
// shifter_pkg: op encodings and per-op helpers shared by the barrel shifter
package shifter_pkg;

    localparam logic [2:0] OP_SLL = 3'd0;
    localparam logic [2:0] OP_SRL = 3'd1;
    localparam logic [2:0] OP_SRA = 3'd2;
    localparam logic [2:0] OP_ROL = 3'd3;
    localparam logic [2:0] OP_ROR = 3'd4;

    function automatic logic op_is_legal(input logic [2:0] op);
        return op <= OP_ROR;
    endfunction

    function automatic logic fill_bit(input logic [2:0] op, input logic msb);
        return (op == OP_SRA) ? msb : 1'b0;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// pipelined_barrel_shifter_if: input beat and result handshakes of the barrel shifter
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 32
) ();
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SHAMT_W-1:0] in_shamt;
    logic [2:0]         in_op;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_zero;
    logic               out_op_err;

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_op_err
    );

    modport master (
        output in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_op_err
    );

endinterface

// File: rtl/pipelined_barrel_shifter_level.sv
// shift_level: one conditional shift/rotate by DIST, right ops done as reverse-left-reverse
module shift_level
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  logic [2:0]       op_i,
    output logic [WIDTH-1:0] data_o
);
    logic             right;
    logic             rot;
    logic [WIDTH-1:0] fwd;
    logic [WIDTH-1:0] sh;

    always_comb begin
        right = (op_i == OP_SRL) || (op_i == OP_SRA) || (op_i == OP_ROR);
        rot   = (op_i == OP_ROL) || (op_i == OP_ROR);
        for (int i = 0; i < WIDTH; i++) fwd[i] = right ? data_i[WIDTH-1-i] : data_i[i];
        sh = {fwd[WIDTH-1-DIST:0], rot ? fwd[WIDTH-1 -: DIST] : {DIST{fill_bit(op_i, data_i[WIDTH-1])}}};
        for (int i = 0; i < WIDTH; i++) data_o[i] = !en_i ? data_i[i] : right ? sh[WIDTH-1-i] : sh[i];
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: multi-mode barrel shifter split over PIPE_STAGES valid/ready register slices
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 2
) (
    input logic                       clock,
    input logic                       reset,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int LEVELS  = SHAMT_W;
    localparam int LPS     = (LEVELS + PIPE_STAGES - 1) / PIPE_STAGES;

    logic [PIPE_STAGES-1:0] valid_q;
    logic [PIPE_STAGES-1:0] err_q;
    logic [WIDTH-1:0]       data_q  [PIPE_STAGES];
    logic [SHAMT_W-1:0]     shamt_q [PIPE_STAGES];
    logic [2:0]             op_q    [PIPE_STAGES];
    logic                   zero_q;
    logic [PIPE_STAGES-1:0] v_in;
    logic [PIPE_STAGES-1:0] err_in;
    logic [SHAMT_W-1:0]     sh_in   [PIPE_STAGES];
    logic [2:0]             op_in   [PIPE_STAGES];
    logic [WIDTH-1:0]       lvl     [PIPE_STAGES][LPS+1];
    logic [PIPE_STAGES:0]   adv;

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign v_in[s]     = bus.in_valid;
            assign lvl[s][0]   = bus.in_data;
            assign sh_in[s]    = bus.in_shamt;
            assign op_in[s]    = bus.in_op;
            assign err_in[s]   = !op_is_legal(bus.in_op);
        end else begin : g_body
            assign v_in[s]     = valid_q[s-1];
            assign lvl[s][0]   = data_q[s-1];
            assign sh_in[s]    = shamt_q[s-1];
            assign op_in[s]    = op_q[s-1];
            assign err_in[s]   = err_q[s-1];
        end
        // slots past LEVELS in the last stages collapse to wires
        for (genvar k = 0; k < LPS; k++) begin : g_lvl
            if (s * LPS + k < LEVELS) begin : g_sh
                shift_level #(
                    .WIDTH (WIDTH),
                    .DIST  (1 << (s * LPS + k))
                ) u_level (
                    .data_i (lvl[s][k]),
                    .en_i   (sh_in[s][s*LPS+k] && !err_in[s]),
                    .op_i   (op_in[s]),
                    .data_o (lvl[s][k+1])
                );
            end else begin : g_pass
                assign lvl[s][k+1] = lvl[s][k];
            end
        end
    end

    always_comb begin
        adv[PIPE_STAGES] = bus.out_ready;
        for (int i = PIPE_STAGES - 1; i >= 0; i--) adv[i] = !valid_q[i] || adv[i+1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            err_q   <= '0;
            zero_q  <= 1'b0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                data_q[i]  <= '0;
                shamt_q[i] <= '0;
                op_q[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < PIPE_STAGES; i++) begin
                if (adv[i]) valid_q[i] <= v_in[i];
                if (adv[i] && v_in[i]) begin
                    data_q[i]  <= lvl[i][LPS];
                    shamt_q[i] <= sh_in[i];
                    op_q[i]    <= op_in[i];
                    err_q[i]   <= err_in[i];
                end
            end
            if (adv[PIPE_STAGES-1] && v_in[PIPE_STAGES-1]) zero_q <= lvl[PIPE_STAGES-1][LPS] == '0;
        end
    end

    assign bus.in_ready   = adv[0];
    assign bus.out_valid  = valid_q[PIPE_STAGES-1];
    assign bus.out_data   = data_q[PIPE_STAGES-1];
    assign bus.out_zero   = zero_q;
    assign bus.out_op_err = err_q[PIPE_STAGES-1];

endmodule
